// File: rtl/sram_controller_if.sv
// sram_controller_if: groups the MEM-stage request/response signals and the
// external 16-bit asynchronous SRAM pad signals of sram_controller.
//   wr_en, rd_en     store / load request levels
//   addr, wdata      byte address and store data
//   rdata, ready     registered load result, 1 = not stalling
//   sram_addr        halfword address to the SRAM
//   sram_dq_out/oe   write data and pad output enable
//   sram_dq_in       read data from the pad
//   sram_*_n         active-low SRAM strobes and byte enables
// slave  : the controller side
// master : the pipeline + SRAM pad side
interface sram_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;
  logic               sram_oe_n;
  logic               sram_ce_n;
  logic               sram_ub_n;
  logic               sram_lb_n;

  modport slave (
    input  wr_en, rd_en, addr, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output wr_en, rd_en, addr, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: sequences a 16-bit asynchronous SRAM for the MEM stage.
// Each 32-bit load/store becomes two halfword accesses (low half, then high
// half), each holding address/control for WAIT_CYCLES cycles.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sram_controller_if.slave (request, response and SRAM pad signals)
// ready is low while an access is in progress; the top level freezes the
// pipeline on ~ready.
module sram_controller #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);
  localparam int         IDX_W    = SRAM_AW - 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t state, state_nxt;

  logic [3:0]       cnt;
  logic             is_wr_q;
  logic [IDX_W-1:0] idx_q;
  logic             half_q;
  logic [31:0]      wdata_q;
  logic [15:0]      lo16;
  logic [31:0]      rdata_q;

  logic             req;
  logic             phase_end;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx_in;

  logic ready;
  logic ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;

  assign req       = bus.wr_en | bus.rd_en;
  assign phase_end = (cnt == CNT_LAST);
  // Truncation to IDX_W bits gives the silent wrap of the word index.
  assign offset    = bus.addr - ADDR_BASE;
  assign idx_in    = IDX_W'(offset >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    ce_n      = 1'b1;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    ub_n      = 1'b1;
    lb_n      = 1'b1;
    dq_oe     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = LO;
      end
      LO, HI: begin
        ce_n = 1'b0;
        ub_n = 1'b0;
        lb_n = 1'b0;
        if (is_wr_q) begin
          dq_oe = 1'b1;
          // Release we_n on the last phase cycle for data hold, unless the
          // phase is a single cycle.
          we_n  = (WAIT_CYCLES > 1) && phase_end;
        end else begin
          oe_n  = 1'b0;
        end
        if (phase_end) state_nxt = (state == LO) ? HI : DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
      lo16    <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            is_wr_q <= bus.wr_en;
            idx_q   <= idx_in;
            wdata_q <= bus.wdata;
            half_q  <= 1'b0;
            cnt     <= '0;
          end
        end
        LO: begin
          if (phase_end) begin
            cnt    <= '0;
            half_q <= 1'b1;
            if (!is_wr_q) lo16 <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (phase_end) begin
            cnt <= '0;
            if (!is_wr_q) rdata_q <= {bus.sram_dq_in, lo16};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and write data come straight from the latched registers, so they
  // hold their last value through DONE/IDLE and read 0 after reset.
  assign bus.sram_addr   = {idx_q, half_q};
  assign bus.sram_dq_out = half_q ? wdata_q[31:16] : wdata_q[15:0];
  assign bus.sram_dq_oe  = dq_oe;
  assign bus.sram_we_n   = we_n;
  assign bus.sram_oe_n   = oe_n;
  assign bus.sram_ce_n   = ce_n;
  assign bus.sram_ub_n   = ub_n;
  assign bus.sram_lb_n   = lb_n;
  assign bus.rdata       = rdata_q;
  assign bus.ready       = ready;

endmodule
